// File: rtl/umi_arb_pkg.sv
// Shared definitions for the UMI arbiter: the EOM bit position in the command and the lock state encoding.
package umi_arb_pkg;
  localparam int UMI_EOM_BIT = 22;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;
endpackage

// File: rtl/umi_arb_agecnt.sv
// Saturating per-input age counter; starved is high once the input has waited AGEMAX cycles.
module umi_arb_agecnt #(
  parameter int AGEW   = 4,
  parameter int AGEMAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic clear,
  output logic starved
);
  logic [AGEW-1:0] age;

  always_ff @(posedge clk) begin
    if (reset)
      age <= '0;
    else if (clear)
      age <= '0;
    else if (waiting && age != AGEW'(AGEMAX))
      age <= age + 1'b1;
  end

  assign starved = (age == AGEW'(AGEMAX));
endmodule

// File: rtl/umi_arbiter.sv
// Packet-aware N:1 UMI arbiter: fixed priority, grant held until EOM, one registered output stage.
// Starvation aging is compiled in only when UMI_ARBITER_AGING_EN is defined.
module umi_arbiter
  import umi_arb_pkg::*;
#(
  parameter int N      = 2,
  parameter int CW     = 32,
  parameter int AW     = 64,
  parameter int DW     = 256,
  parameter int AGEW   = 4,
  parameter int AGEMAX = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]  umi_in_ready,
  output logic          umi_out_valid,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data,
  input  logic          umi_out_ready,
  output logic [N-1:0]  arb_owner,
  output logic          arb_locked
);
  arb_state_e state_q, state_d;
  logic [N-1:0]  owner_q, owner_d;
  logic [N-1:0]  win, pool, acc_vec, starved;
  logic          load_ok, acc, found;
  logic [CW-1:0] mux_cmd;
  logic [AW-1:0] mux_dst, mux_src;
  logic [DW-1:0] mux_data;

  assign load_ok = ~umi_out_valid | umi_out_ready;

`ifdef UMI_ARBITER_AGING_EN
  for (genvar i = 0; i < N; i++) begin : g_age
    umi_arb_agecnt #(.AGEW(AGEW), .AGEMAX(AGEMAX)) u_age (
      .clk     (clk),
      .reset   (reset),
      .waiting (umi_in_valid[i] & ~acc_vec[i]),
      .clear   (~umi_in_valid[i] | acc_vec[i]),
      .starved (starved[i])
    );
  end
`else
  logic unused_age_cfg;
  assign starved        = '0;
  assign unused_age_cfg = ^{32'(AGEW), 32'(AGEMAX)};
`endif

  // Locked: only the owner may win, even while it bubbles.
  always_comb begin
    win   = '0;
    found = 1'b0;
    pool  = (|(umi_in_valid & starved)) ? (umi_in_valid & starved) : umi_in_valid;
    if (state_q == LOCKED) begin
      win = owner_q;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (pool[i] && !found) begin
          win[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  assign umi_in_ready = win & {N{load_ok & ~reset}};
  assign acc_vec      = umi_in_ready & umi_in_valid;
  assign acc          = |acc_vec;

  always_comb begin
    mux_cmd  = '0;
    mux_dst  = '0;
    mux_src  = '0;
    mux_data = '0;
    for (int i = 0; i < N; i++) begin
      if (win[i]) begin
        mux_cmd  = umi_in_cmd[i*CW +: CW];
        mux_dst  = umi_in_dstaddr[i*AW +: AW];
        mux_src  = umi_in_srcaddr[i*AW +: AW];
        mux_data = umi_in_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (acc) begin
      if (mux_cmd[UMI_EOM_BIT]) begin
        state_d = IDLE;
        owner_d = '0;
      end else begin
        state_d = LOCKED;
        owner_d = win;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= '0;
      umi_out_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (load_ok)
        umi_out_valid <= acc;
    end
  end

  // Payload needs no reset; it is qualified by umi_out_valid.
  always_ff @(posedge clk) begin
    if (acc) begin
      umi_out_cmd     <= mux_cmd;
      umi_out_dstaddr <= mux_dst;
      umi_out_srcaddr <= mux_src;
      umi_out_data    <= mux_data;
    end
  end

  assign arb_locked = (state_q == LOCKED);
  assign arb_owner  = owner_q;
endmodule

// File: tb/tb_umi_arbiter.sv
// Directed bench for umi_arbiter; the arbitration-order test follows UMI_ARBITER_AGING_EN.
module tb_umi_arbiter;
  localparam int N = 2, CW = 32, AW = 64, DW = 64;
  localparam logic [CW-1:0] EOM1 = 32'h0040_0000;
  localparam logic [CW-1:0] EOM0 = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  in_valid;
  logic [N*CW-1:0] in_cmd;
  logic [N*AW-1:0] in_dst, in_src;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          out_valid, out_ready, locked;
  logic [CW-1:0] out_cmd;
  logic [AW-1:0] out_dst, out_src;
  logic [DW-1:0] out_data;
  logic [N-1:0]  owner;

  int nvec = 0;
  int nerr = 0;

  umi_arbiter #(.N(N), .CW(CW), .AW(AW), .DW(DW), .AGEW(2), .AGEMAX(3)) dut (
    .clk(clk), .reset(reset),
    .umi_in_valid(in_valid), .umi_in_cmd(in_cmd), .umi_in_dstaddr(in_dst),
    .umi_in_srcaddr(in_src), .umi_in_data(in_data), .umi_in_ready(in_ready),
    .umi_out_valid(out_valid), .umi_out_cmd(out_cmd), .umi_out_dstaddr(out_dst),
    .umi_out_srcaddr(out_src), .umi_out_data(out_data), .umi_out_ready(out_ready),
    .arb_owner(owner), .arb_locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int i, input logic v, input logic [CW-1:0] cmd,
                        input logic [AW-1:0] dst, input logic [DW-1:0] data);
    in_valid[i]          = v;
    in_cmd[i*CW +: CW]   = cmd;
    in_dst[i*AW +: AW]   = dst;
    in_src[i*AW +: AW]   = 64'hA0 + 64'(i);
    in_data[i*DW +: DW]  = data;
  endtask

  // Advance past the next rising edge and let registered outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = '0;
    in_cmd    = '0;
    in_dst    = '0;
    in_src    = '0;
    in_data   = '0;
    set_in(0, 1'b1, EOM1, 64'h0, 64'hDEAD);
    #2;
    chk("rst_ready", 64'(in_ready), 64'h0);
    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_locked", 64'(locked), 64'h0);
    chk("rst_owner", 64'(owner), 64'h0);
    set_in(0, 1'b0, EOM1, 64'h0, 64'h0);
    reset = 1'b0;
    tick();

    // Both inputs continuously valid, single-beat packets.
    for (int k = 0; k < 8; k++) begin
      set_in(0, 1'b1, EOM1, 64'h0, 64'h100 + 64'(k));
      set_in(1, 1'b1, EOM1, 64'h0, 64'h200 + 64'(k));
      #2;
`ifndef UMI_ARBITER_AGING_EN
      chk("prio_ready1", 64'(in_ready[1]), 64'h0);
`endif
      tick();
      chk("prio_vld", 64'(out_valid), 64'h1);
`ifdef UMI_ARBITER_AGING_EN
      chk("age_order", out_data, (k % 4 == 3) ? 64'h200 + 64'(k) : 64'h100 + 64'(k));
`else
      chk("prio_data", out_data, 64'h100 + 64'(k));
`endif
    end
    set_in(0, 1'b0, EOM1, 64'h0, 64'h0);
    set_in(1, 1'b0, EOM1, 64'h0, 64'h0);
    tick();
    chk("drain_vld", 64'(out_valid), 64'h0);

    // in1 three-beat packet; in0 arrives mid-packet and must wait.
    set_in(1, 1'b1, EOM0, 64'h0, 64'hA1);
    tick();
    chk("pkt_b1", out_data, 64'hA1);
    chk("pkt_lock1", 64'(locked), 64'h1);
    set_in(1, 1'b1, EOM0, 64'h0, 64'hA2);
    set_in(0, 1'b1, EOM1, 64'h0, 64'hB0);
    #2;
    chk("pkt_rdy0_b2", 64'(in_ready), 64'h2);
    tick();
    chk("pkt_b2", out_data, 64'hA2);
    chk("pkt_owner", 64'(owner), 64'h2);
    set_in(1, 1'b1, EOM1, 64'h0, 64'hA3);
    #2;
    chk("pkt_rdy0_b3", 64'(in_ready[0]), 64'h0);
    tick();
    chk("pkt_b3", out_data, 64'hA3);
    chk("pkt_unlock", 64'(locked), 64'h0);
    chk("pkt_owner0", 64'(owner), 64'h0);
    set_in(1, 1'b0, EOM1, 64'h0, 64'h0);
    #2;
    chk("pkt_rdy0_after", 64'(in_ready[0]), 64'h1);
    tick();
    chk("pkt_in0", out_data, 64'hB0);
    set_in(0, 1'b0, EOM1, 64'h0, 64'h0);
    tick();

    // Single beat latency, then five cycles of backpressure.
    set_in(0, 1'b1, EOM1, 64'h1000, 64'hD0);
    tick();
    chk("lat_vld", 64'(out_valid), 64'h1);
    chk("lat_dst", out_dst, 64'h1000);
    chk("lat_src", out_src, 64'hA0);
    out_ready = 1'b0;
    set_in(0, 1'b1, EOM1, 64'h2000, 64'hD1);
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("bp_ready", 64'(in_ready), 64'h0);
      tick();
      chk("bp_vld", 64'(out_valid), 64'h1);
      chk("bp_data", out_data, 64'hD0);
      chk("bp_dst", out_dst, 64'h1000);
    end
    out_ready = 1'b1;
    #2;
    chk("bp_release_rdy", 64'(in_ready), 64'h1);
    tick();
    chk("bp_next", out_data, 64'hD1);
    chk("bp_next_dst", out_dst, 64'h2000);
    set_in(0, 1'b0, EOM1, 64'h0, 64'h0);
    tick();

    // Reset while locked with a stalled output beat.
    out_ready = 1'b0;
    set_in(1, 1'b1, EOM0, 64'h0, 64'hC1);
    tick();
    set_in(1, 1'b0, EOM0, 64'h0, 64'h0);
    chk("mid_locked", 64'(locked), 64'h1);
    chk("mid_vld", 64'(out_valid), 64'h1);
    set_in(0, 1'b1, EOM1, 64'h0, 64'hE0);
    reset = 1'b1;
    out_ready = 1'b1;
    #2;
    chk("mid_rst_ready", 64'(in_ready), 64'h0);
    tick();
    reset = 1'b0;
    chk("mid_rst_vld", 64'(out_valid), 64'h0);
    chk("mid_rst_lock", 64'(locked), 64'h0);
    chk("mid_rst_owner", 64'(owner), 64'h0);
    #2;
    chk("post_rst_rdy", 64'(in_ready), 64'h1);
    tick();
    chk("post_rst_vld", 64'(out_valid), 64'h1);
    chk("post_rst_data", out_data, 64'hE0);
    set_in(0, 1'b0, EOM1, 64'h0, 64'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
